maxpool2x2_stream: RTL

- Streaming 2x2, stride-2 max-pooling stage directly downstream of the 6-input partial-conv unit.
- Consumes that unit's clipped, ReLU'd conv_dout / conv_dout_vld pixel stream for one output channel, in raster order (row-major, IMG_W x IMG_H).
- Emits one pooled pixel per 2x2 window: an (IMG_W/2) x (IMG_H/2) raster stream feeding the next conv layer's input buffer.
- Uses one half-width line buffer of horizontal maxima; no frame storage.

---
 rtl/maxpool2x2_stream.sv | 87 ++++++++
 1 files changed

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over a raster pixel stream, one line buffer.
// Define MAXPOOL_SIGNED_EN for two's-complement comparison (default unsigned).
module maxpool2x2_stream #(
    parameter int N     = 16,
    parameter int IMG_W = 24,
    parameter int IMG_H = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din_vld,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         dout_vld,
    output logic         dout_end
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LW = (CW > 1) ? CW - 1 : 1;
    localparam int LD = IMG_W / 2;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [N-1:0]  r_hold;
    logic [N-1:0]  r_line [LD];

    logic          w_col_odd;
    logic          w_row_odd;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_fire;
    logic [LW-1:0] w_lidx;
    logic [N-1:0]  w_hmax;
    logic [N-1:0]  w_pool;

    function automatic logic [N-1:0] f_max(input logic [N-1:0] a,
                                           input logic [N-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
        return ($signed(a) > $signed(b)) ? a : b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

    assign w_col_odd  = r_col[0];
    assign w_row_odd  = r_row[0];
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    assign w_lidx     = LW'(r_col >> 1);
    assign w_hmax     = f_max(r_hold, din);
    assign w_pool     = f_max(r_line[w_lidx], w_hmax);
    assign w_fire     = din_vld & w_col_odd & w_row_odd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col    <= '0;
            r_row    <= '0;
            r_hold   <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_end <= 1'b0;
        end else begin
            dout_vld <= w_fire;
            dout_end <= w_fire & w_col_last & w_row_last;
            if (w_fire)
                dout <= w_pool;
            if (din_vld) begin
                if (!w_col_odd)
                    r_hold <= din;
                // IMG_W is even, so the last column is always odd
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    // Written on every even-row pair before the odd row reads it; no reset needed
    always_ff @(posedge clk) begin
        if (din_vld && w_col_odd && !w_row_odd)
            r_line[w_lidx] <= w_hmax;
    end

endmodule
